// File: rtl/controlo_display.sv
// controlo_display
// Captures one arithmetic result on a button press and presents it one hex
// digit at a time, most significant first. Each digit is held for HOLD clock
// cycles, and the sequence repeats until it is cleared or a new result is
// captured.
//
// Ports
//   relogio  system clock (rising edge)
//   reset    asynchronous, active-high
//   butSOM/butSUB/butDIV/butMUL  debounced request levels; the rising edge is
//            what counts. Priority is MUL > DIV > SUB > SOM.
//   apagar   synchronous clear; wins over a request in the same cycle
//   dspsom/dspsub/dspdiv  9-bit results, bit 8 = sign, bits 7:0 shown
//   dspmul   18-bit result, bit 17 = sign, bits 15:0 shown (bit 16 unused)
//   digito   nibble currently presented
//   posicao  digit position of digito (0 = least significant)
//   negativo sign of the captured result
//   operacao captured source: 00 som, 01 sub, 10 div, 11 mul
//   valido   presentation outputs are meaningful
//   novo     one-cycle pulse on the first cycle of a fresh capture
module controlo_display #(
  parameter int HOLD = 4
) (
  input  logic        relogio,
  input  logic        reset,
  input  logic        butSOM,
  input  logic        butSUB,
  input  logic        butDIV,
  input  logic        butMUL,
  input  logic        apagar,
  input  logic [8:0]  dspsom,
  input  logic [8:0]  dspsub,
  input  logic [8:0]  dspdiv,
  input  logic [17:0] dspmul,
  output logic [3:0]  digito,
  output logic [1:0]  posicao,
  output logic        negativo,
  output logic [1:0]  operacao,
  output logic        valido,
  output logic        novo
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  localparam logic [1:0] OP_SOM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state;
  logic [3:0]  btn;      // {MUL, DIV, SUB, SOM}
  logic [3:0]  btn_q;
  logic [3:0]  req;
  logic [7:0]  cnt;
  logic [15:0] opnd;

  logic        sel_vld;
  logic [1:0]  sel_op;
  logic [15:0] sel_opnd;
  logic        sel_neg;
  logic [1:0]  sel_last;

  logic [1:0]  cur_last;
  logic [1:0]  pos_nxt;

  // MUL bit 16 is never displayed.
  logic unused_mul16;
  assign unused_mul16 = dspmul[16];

  assign btn = {butMUL, butDIV, butSUB, butSOM};
  assign req = btn & ~btn_q;

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] p);
    return v[{p, 2'b00} +: 4];
  endfunction

  // Fixed-priority pick of the incoming request and its operand.
  always_comb begin
    sel_vld  = |req;
    sel_op   = OP_SOM;
    sel_opnd = {8'h00, dspsom[7:0]};
    sel_neg  = dspsom[8];
    if (req[3]) begin
      sel_op   = OP_MUL;
      sel_opnd = dspmul[15:0];
      sel_neg  = dspmul[17];
    end else if (req[2]) begin
      sel_op   = OP_DIV;
      sel_opnd = {8'h00, dspdiv[7:0]};
      sel_neg  = dspdiv[8];
    end else if (req[1]) begin
      sel_op   = OP_SUB;
      sel_opnd = {8'h00, dspsub[7:0]};
      sel_neg  = dspsub[8];
    end
    sel_last = (sel_op == OP_MUL) ? 2'd3 : 2'd1;
  end

  // Digit count follows the latched source, so no separate length register.
  assign cur_last = (operacao == OP_MUL) ? 2'd3 : 2'd1;
  assign pos_nxt  = (posicao == 2'd0) ? cur_last : posicao - 2'd1;

  always_ff @(posedge relogio or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      btn_q    <= '0;
      cnt      <= '0;
      opnd     <= '0;
      digito   <= '0;
      posicao  <= '0;
      negativo <= 1'b0;
      operacao <= OP_SOM;
      valido   <= 1'b0;
      novo     <= 1'b0;
    end else begin
      // Buttons are always registered, so a request coinciding with apagar
      // is consumed rather than deferred.
      btn_q <= btn;
      novo  <= 1'b0;
      if (apagar) begin
        state    <= IDLE;
        cnt      <= '0;
        opnd     <= '0;
        digito   <= '0;
        posicao  <= '0;
        negativo <= 1'b0;
        operacao <= OP_SOM;
        valido   <= 1'b0;
      end else if (sel_vld) begin
        // Capture is allowed in either state; it always restarts at the top digit.
        state    <= SHOW;
        cnt      <= '0;
        opnd     <= sel_opnd;
        negativo <= sel_neg;
        operacao <= sel_op;
        posicao  <= sel_last;
        digito   <= nib(sel_opnd, sel_last);
        valido   <= 1'b1;
        novo     <= 1'b1;
      end else if (state == SHOW) begin
        if (cnt == HOLD_LAST) begin
          cnt     <= '0;
          posicao <= pos_nxt;
          digito  <= nib(opnd, pos_nxt);
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_controlo_display.sv
// Scoreboarded bench for controlo_display (HOLD = 2). The driver applies one
// input vector per cycle, advances a reference model that works from elapsed
// cycles since capture, and queues the expected outputs; the monitor pops and
// compares one entry after each clock edge.
module tb_controlo_display;

  localparam int HOLD = 2;

  logic        relogio, reset;
  logic        butSOM, butSUB, butDIV, butMUL, apagar;
  logic [8:0]  dspsom, dspsub, dspdiv;
  logic [17:0] dspmul;
  logic [3:0]  digito;
  logic [1:0]  posicao;
  logic        negativo;
  logic [1:0]  operacao;
  logic        valido, novo;

  controlo_display #(.HOLD(HOLD)) dut (
    .relogio(relogio), .reset(reset),
    .butSOM(butSOM), .butSUB(butSUB), .butDIV(butDIV), .butMUL(butMUL),
    .apagar(apagar),
    .dspsom(dspsom), .dspsub(dspsub), .dspdiv(dspdiv), .dspmul(dspmul),
    .digito(digito), .posicao(posicao), .negativo(negativo),
    .operacao(operacao), .valido(valido), .novo(novo)
  );

  initial relogio = 1'b0;
  always #5 relogio = ~relogio;

  typedef struct packed {
    logic       valido;
    logic       novo;
    logic [3:0] digito;
    logic [1:0] posicao;
    logic       negativo;
    logic [1:0] operacao;
  } out_t;

  out_t act;
  assign act = {valido, novo, digito, posicao, negativo, operacao};

  out_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: what was captured and how long ago.
  logic [3:0]  m_bq   = '0;
  bit          m_act  = 0;
  logic [15:0] m_opnd = '0;
  int          m_n    = 2;
  logic [1:0]  m_op   = '0;
  logic        m_neg  = 0;
  int          m_t    = 0;

  logic [3:0]  cur_b = '0;

  function automatic out_t model_out();
    out_t o;
    int   k, pos;
    o = '0;
    if (m_act) begin
      k = (m_t / HOLD) % m_n;
      pos = m_n - 1 - k;
      o.valido   = 1'b1;
      o.novo     = (m_t == 0);
      o.digito   = 4'((m_opnd >> (4 * pos)) & 16'hF);
      o.posicao  = 2'(pos);
      o.negativo = m_neg;
      o.operacao = m_op;
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got v=%b nv=%b d=%h p=%0d neg=%b op=%0d, want v=%b nv=%b d=%h p=%0d neg=%b op=%0d",
               name, got.valido, got.novo, got.digito, got.posicao, got.negativo, got.operacao,
               exp.valido, exp.novo, exp.digito, exp.posicao, exp.negativo, exp.operacao);
    end
  endtask

  // Apply inputs for the coming edge and queue what the outputs must be after it.
  task automatic drive(input logic [3:0] b, input logic ap, input logic [8:0] s,
                       input logic [8:0] u, input logic [8:0] d, input logic [17:0] m);
    logic [3:0] req;
    {butMUL, butDIV, butSUB, butSOM} = b;
    apagar = ap;
    dspsom = s; dspsub = u; dspdiv = d; dspmul = m;
    req = b & ~m_bq;
    if (ap) begin
      m_act = 0;
    end else if (req != 4'b0) begin
      m_act = 1;
      m_t   = 0;
      if (req[3]) begin
        m_op = 2'd3; m_opnd = m[15:0]; m_neg = m[17]; m_n = 4;
      end else if (req[2]) begin
        m_op = 2'd2; m_opnd = {8'h0, d[7:0]}; m_neg = d[8]; m_n = 2;
      end else if (req[1]) begin
        m_op = 2'd1; m_opnd = {8'h0, u[7:0]}; m_neg = u[8]; m_n = 2;
      end else begin
        m_op = 2'd0; m_opnd = {8'h0, s[7:0]}; m_neg = s[8]; m_n = 2;
      end
    end else if (m_act) begin
      m_t++;
    end
    m_bq = b;
    q.push_back(model_out());
  endtask

  task automatic step(input logic [3:0] b, input logic ap, input logic [8:0] s,
                      input logic [8:0] u, input logic [8:0] d, input logic [17:0] m);
    @(posedge relogio); #3;
    drive(b, ap, s, u, d, m);
  endtask

  // Operands change every cycle so a re-sampling design would be caught.
  task automatic step_r(input logic [3:0] b, input logic ap);
    step(b, ap, 9'($urandom), 9'($urandom), 9'($urandom), 18'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_r(4'b0, 1'b0);
  endtask

  // Monitor: one expected entry per observed cycle.
  initial begin
    out_t e;
    forever begin
      @(posedge relogio); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", act, e);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {butMUL, butDIV, butSUB, butSOM} = '0;
    apagar = 0; dspsom = '0; dspsub = '0; dspdiv = '0; dspmul = '0;
    #1 check("reset_state", act, '0);
    #11;
    reset = 1'b0;
    drive(4'b0, 1'b0, '0, '0, '0, '0);

    // SOM 0x1A5: A then 5, two cycles each, negative
    step(4'b0001, 1'b0, 9'h1A5, 9'h0, 9'h0, 18'h0);
    idle(7);
    // MUL 0x2BEEF: B E E F
    step(4'b1000, 1'b0, 9'h0, 9'h0, 9'h0, 18'h2BEEF);
    idle(12);
    // SOM and MUL together: MUL wins
    step(4'b1001, 1'b0, 9'h0C3, 9'h0, 9'h0, 18'h01234);
    idle(9);
    // apagar with DIV rising, DIV held 5 cycles: nothing captured
    step(4'b0100, 1'b1, 9'h0, 9'h0, 9'h077, 18'h0);
    for (int i = 0; i < 4; i++) step_r(4'b0100, 1'b0);
    idle(3);
    // SUB during MUL at posicao 2, counter 1
    step(4'b1000, 1'b0, 9'h0, 9'h0, 9'h0, 18'h0A5C3);
    idle(3);
    step(4'b0010, 1'b0, 9'h0, 9'h13C, 9'h0, 18'h0);
    idle(6);

    // randomized traffic; buttons tend to be held for a few cycles
    for (int i = 0; i < 500; i++) begin
      for (int j = 0; j < 4; j++)
        if (cur_b[j]) cur_b[j] = ($urandom_range(0, 2) != 0);
        else          cur_b[j] = ($urandom_range(0, 11) == 0);
      step_r(cur_b, $urandom_range(0, 39) == 0);
    end
    cur_b = '0;
    idle(2);

    // reset mid-SHOW with MUL held through release
    step(4'b1000, 1'b0, 9'h0, 9'h0, 9'h0, 18'h3CAFE);
    step_r(4'b0, 1'b0);
    step_r(4'b0, 1'b0);
    @(posedge relogio); #3;   // queue drained by the monitor at +1
    reset = 1'b1;
    {butMUL, butDIV, butSUB, butSOM} = 4'b1000;
    #1 check("async_reset", act, '0);
    @(posedge relogio); #4;
    check("reset_held", act, '0);
    reset  = 1'b0;
    m_act  = 0;
    m_bq   = '0;
    drive(4'b1000, 1'b0, '0, '0, '0, 18'h15A69);
    idle(10);

    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < 4; j++)
        if (cur_b[j]) cur_b[j] = ($urandom_range(0, 2) != 0);
        else          cur_b[j] = ($urandom_range(0, 9) == 0);
      step_r(cur_b, $urandom_range(0, 29) == 0);
    end

    repeat (3) @(posedge relogio);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlo_display.md
CONTROLO_DISPLAY -- requirements
Module: controlo_display

Interface
REQ-001 Parameter: HOLD, default 4, number of relogio cycles each digit is presented (legal range 1..255).
REQ-002 relogio  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 butSOM  input  1  request to show sum result; synchronous to relogio; debounced level.
REQ-005 butSUB  input  1  request to show subtraction result; same rules as butSOM.
REQ-006 butDIV  input  1  request to show division result; same rules as butSOM.
REQ-007 butMUL  input  1  request to show multiplication result; same rules as butSOM.
REQ-008 apagar  input  1  synchronous clear of the display sequence.
REQ-009 dspsom  input  9  sum result; bit 8 is the sign.
REQ-010 dspsub  input  9  subtraction result; bit 8 is the sign.
REQ-011 dspdiv  input  9  division result; bit 8 is the sign.
REQ-012 dspmul  input  18  multiplication result; bit 17 is the sign.
REQ-013 digito  output  4  hex nibble currently presented.
REQ-014 posicao  output  2  digit position of digito (0 = least significant).
REQ-015 negativo  output  1  sign bit of the captured result.
REQ-016 operacao  output  2  captured source: 00 som, 01 sub, 10 div, 11 mul.
REQ-017 valido  output  1  high while digito/posicao/negativo/operacao are meaningful.
REQ-018 novo  output  1  one-cycle pulse in the first presentation cycle of a new capture.

Function
REQ-019 Each button is registered every cycle; a request is a rising edge: button = 1 while its registered copy = 0.
REQ-020 Simultaneous requests are resolved by fixed priority MUL > DIV > SUB > SOM; losing requests are discarded and never serviced later.
REQ-021 States: IDLE and SHOW.
REQ-022 IDLE: valido = 0, digito = 0, posicao = 0, hold counter = 0.
REQ-023 On an accepted request, the selected operand, its sign and operacao are latched at that edge, and the block enters SHOW with posicao = N-1 and hold counter = 0.
REQ-024 Latency: valido = 1 and novo = 1 in the cycle immediately after the edge at which the request was sampled.
REQ-025 Digit count N is 4 for MUL, showing bits 15:0. N is 2 for SOM, SUB and DIV, showing bits 7:4 then 3:0. MUL bit 16 is ignored.
REQ-026 digito always equals the latched operand nibble selected by posicao; the operand is not re-sampled after capture.
REQ-027 SHOW: the hold counter increments each cycle; when it reaches HOLD-1 it clears and posicao decrements.
REQ-028 Wrap-around: when posicao = 0 and the hold counter reaches HOLD-1, posicao returns to N-1; the display repeats indefinitely.
REQ-029 A new accepted request in SHOW, at any counter value, re-captures per REQ-023, restarts at posicao N-1 and pulses novo.
REQ-030 apagar = 1: next state IDLE with all outputs at IDLE values; apagar has priority over any request in the same cycle, and that request is consumed.
REQ-031 A button held high produces exactly one request; releasing and re-pressing produces another.

Reset
REQ-032 While reset = 1: state IDLE, all outputs 0, hold counter 0, latched operand 0, button registers 0; all effective immediately, without a clock edge.
REQ-033 A button already high when reset deasserts counts as a request at the first relogio edge.
REQ-034 Reset asserted mid-SHOW aborts the sequence; the interrupted result is not resumed.

Verification (HOLD = 2)
REQ-035 Reset, dspsom = 9'h1A5, butSOM raised for one cycle -> next cycle valido = 1, novo = 1, operacao = 00, negativo = 1, posicao = 1, digito = A for 2 cycles, then posicao = 0, digito = 5 for 2 cycles, then posicao = 1 again.
REQ-036 dspmul = 18'h2BEEF, butMUL pulse -> negativo = 1, operacao = 11, digits B, E, E, F at posicao 3..0, 2 cycles each, then repeats from posicao 3.
REQ-037 butSOM and butMUL rising in the same cycle -> operacao = 11, N = 4; no SOM display follows.
REQ-038 apagar and butDIV rising together, butDIV held high 5 cycles -> valido stays 0, no capture.
REQ-039 butSUB pulse during SHOW of a MUL result at posicao 2, counter 1 -> next cycle operacao = 01, posicao = 1, novo = 1.
REQ-040 reset raised between clock edges mid-SHOW -> all outputs 0 before the next relogio edge; with butMUL held through reset release -> capture at the first edge.
